// File: rtl/pipe_fifo_chain_pkg.sv
// Shared defaults and helpers for the pipe_fifo_chain elastic buffer.
// The occupancy width sizes the optional level output (PIPE_FIFO_CHAIN_LEVEL_EN).
package pipe_fifo_chain_pkg;

    localparam int DEF_D_WIDTH   = 6;
    localparam int DEF_A_WIDTH   = 2;
    localparam int DEF_N_STAGES  = 4;
    localparam int DEF_AF_THRESH = 3;

    // Bits needed to hold 0 .. n_stages + 2**a_width words.
    function automatic int occ_width(input int n_stages, input int a_width);
        return $clog2(n_stages + (1 << a_width) + 1);
    endfunction

endpackage

// File: rtl/pfc_reg_slice.sv
// One full-throughput valid/ready register slice with synchronous flush.
// Loads whenever it is empty or its contents leave on the same edge.
module pfc_reg_slice
    import pipe_fifo_chain_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready
);

    logic load;

    assign load = !down_valid || down_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_valid <= 1'b0;
        end else if (flush) begin
            down_valid <= 1'b0;
        end else if (load) begin
            down_valid <= up_valid;
        end
    end

    // Payload is qualified by down_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load && up_valid) begin
            down_data <= up_data;
        end
    end

endmodule

// File: rtl/pipe_fifo_chain.sv
// Elastic buffer: N_STAGES register slices feeding a 2**A_WIDTH-deep FIFO.
// Optional macro PIPE_FIFO_CHAIN_LEVEL_EN adds a registered total-occupancy output.
module pipe_fifo_chain
    import pipe_fifo_chain_pkg::*;
#(
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int N_STAGES  = DEF_N_STAGES,
    parameter int AF_THRESH = DEF_AF_THRESH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic               almost_full
`ifdef PIPE_FIFO_CHAIN_LEVEL_EN
    ,
    output logic [occ_width(N_STAGES, A_WIDTH)-1:0] level
`endif
);

    localparam int                 DEPTH     = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0]   DEPTH_CNT = (A_WIDTH + 1)'(DEPTH);
    localparam logic [A_WIDTH:0]   AF_CNT    = (A_WIDTH + 1)'(AF_THRESH);

    // Node j is the word presented to slice j (node 0 = up side, node N_STAGES = FIFO input).
    logic [N_STAGES:0][D_WIDTH-1:0] data_at;
    logic [N_STAGES:0]              valid_at;
    logic [N_STAGES:0]              ready_at;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;
    logic [A_WIDTH:0]   count;
    logic               fifo_has_room;
    logic               wr_en;
    logic               rd_en;

    assign data_at[0]  = up_data;
    assign valid_at[0] = up_valid;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        pfc_reg_slice #(
            .D_WIDTH(D_WIDTH)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .up_data   (data_at[i]),
            .up_valid  (valid_at[i]),
            .down_data (data_at[i+1]),
            .down_valid(valid_at[i+1]),
            .down_ready(ready_at[i+1])
        );
    end

    // The ready ripple collapses to "FIFO has room or some slot downstream is empty";
    // evaluating it per node from registered valids keeps the path loop-free.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        ready_at = '0;
        for (int j = 0; j <= N_STAGES; j++) begin
            ready_at[j] = fifo_has_room;
            for (int m = j + 1; m <= N_STAGES; m++) begin
                if (!valid_at[m]) begin
                    ready_at[j] = 1'b1;
                end
            end
        end
    end

    assign up_ready      = ready_at[0] && !flush && !rst;
    assign fifo_has_room = (count < DEPTH_CNT);
    assign wr_en         = valid_at[N_STAGES] && fifo_has_room && !flush;
    assign down_valid    = (count != '0) && !flush;
    assign rd_en         = down_valid && down_ready;
    assign down_data     = mem[rd_ptr];
    assign almost_full   = (count >= AF_CNT);

    // NOTE: FIFO storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_at[N_STAGES];
        end
    end

    // A full FIFO refuses the write even when a read frees a slot on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_FIFO_CHAIN_LEVEL_EN
    localparam int L_WIDTH = occ_width(N_STAGES, A_WIDTH);

    logic up_fire;

    // Words only enter at the up side and leave at the down side, so those two
    // handshakes fully determine total occupancy.
    assign up_fire = up_valid && up_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case ({up_fire, rd_en})
                2'b10:   level <= level + L_WIDTH'(1);
                2'b01:   level <= level - L_WIDTH'(1);
                default: level <= level;
            endcase
        end
    end
`endif

endmodule
